// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side (IF, LS) and memory-side handshakes of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Instruction fetch
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    // Load/store
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic [BE_WIDTH-1:0]   ls_be;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_WIDTH-1:0] ls_rdata;

    // Unified memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, if_flush,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store.
// One transaction outstanding at a time, LS has priority over IF, an in-flight fetch can be
// squashed by if_flush. Define MEM_ARB_FAIRNESS_EN to let IF win after STARVE_MAX consecutive
// LS grants taken while IF was waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                clk,
    input logic                reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic {OwnIf, OwnLs} owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   drop_q, drop_d;

    owner_e cur_owner;  // owner this cycle: live winner in StIdle, locked owner otherwise
    logic   req_valid;  // a request is presented to memory (before reset gating)
    logic   rsp;        // memory response consumed this cycle
    logic   gnt;
    logic   if_active;  // an IF transaction is presented or outstanding
    logic   starved;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    assign starved = bus.if_req & (starve_q >= StarveMax);

    // Count LS grants taken while IF waits; saturate so a late if_req cannot wrap it.
    always_comb begin
        starve_d = starve_q;
        if (bus.ls_gnt) begin
            if (bus.if_req) begin
                starve_d = (starve_q == 4'hf) ? starve_q : starve_q + 4'd1;
            end else begin
                starve_d = '0;
            end
        end else if (bus.if_gnt) begin
            starve_d = '0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Arbitration and transaction sequencing
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cur_owner = owner_q;
        req_valid = 1'b0;
        rsp       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ls_req && !starved) begin
                    cur_owner = OwnLs;
                    req_valid = 1'b1;
                end else if (bus.if_req) begin
                    cur_owner = OwnIf;
                    req_valid = 1'b1;
                end
                if (req_valid) begin
                    owner_d = cur_owner;
                    state_d = bus.mem_gnt ? StWait : StReq;
                end
            end
            StReq: begin
                req_valid = 1'b1;
                if (bus.mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                rsp = bus.mem_rvalid;
                if (bus.mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign if_active = (req_valid | (state_q == StWait)) & (cur_owner == OwnIf);

    // Drop flag: a flush anywhere in an IF transaction's life squashes its response
    always_comb begin
        drop_d = drop_q;
        if (bus.if_flush && if_active) begin
            drop_d = 1'b1;
        end
        if (rsp && cur_owner == OwnIf) begin
            drop_d = 1'b0;
        end
    end

    // State, owner and drop flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= OwnIf;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
        end
    end

    // Handshake outputs are forced low while reset is held
    assign gnt           = reset_n & req_valid & bus.mem_gnt;
    assign bus.mem_req   = reset_n & req_valid;
    assign bus.if_gnt    = gnt & (cur_owner == OwnIf);
    assign bus.ls_gnt    = gnt & (cur_owner == OwnLs);
    assign bus.ls_rvalid = reset_n & rsp & (cur_owner == OwnLs);
    // A flush arriving in the response cycle squashes that same response
    assign bus.if_rvalid = reset_n & rsp & (cur_owner == OwnIf) & ~drop_q & ~bus.if_flush;

    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    // Memory request fields muxed from the current owner
    always_comb begin
        if (cur_owner == OwnLs) begin
            bus.mem_we    = bus.ls_we;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
            bus.mem_be    = bus.ls_be;
        end else begin
            bus.mem_we    = 1'b0;
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = '0;
            bus.mem_be    = {BE_WIDTH{1'b1}};
        end
    end

    // Keep widths of the interface and module parameters tied together
    logic [ADDR_WIDTH-1:0] unused_addr_chk;
    assign unused_addr_chk = bus.mem_addr;
endmodule
